mem_port_arbiter: RTL

- Shares one tagged unified memory (BUS_NONE/LOAD/STORE command, nonzero response tag on accept, data returned later with matching tag) between the instruction-fetch port and the data-memory port of the pipeline.
- Sits between the processor's IF/MEM stages and a single memory instance.
- Grants one request per cycle and records which requester owns each outstanding load tag.
- Routes each returning load to its owner, with bounded-starvation priority.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_tag_table.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/DM memory port arbiter.
package mem_arb_pkg;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } tag_entry_t;

endpackage

// File: rtl/arb_tag_table.sv
// Outstanding-load owner table: one entry per memory tag, set on accept,
// read and cleared on return.
module arb_tag_table
   import mem_arb_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [TAG_W-1:0] set_tag,
   input  owner_t           set_owner,
   input  logic [TAG_W-1:0] ret_tag,
   output logic             ret_hit,
   output owner_t           ret_owner,
   output logic             err
);

   localparam int unsigned DEPTH = 2 ** TAG_W;

   tag_entry_t entry [0:DEPTH-1];

   // Combinational lookup of the returning tag's owner.
   always_comb begin
      ret_hit   = (ret_tag != '0) && entry[ret_tag].valid;
      ret_owner = entry[ret_tag].owner;
   end

   // Clear on return, then set on accept: the later write wins when the
   // same tag is returned and reissued in one cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry[i] <= '{valid: 1'b0, owner: OWN_IF};
         end
         err <= 1'b0;
      end else begin
         if (ret_tag != '0) begin
            if (entry[ret_tag].valid) begin
               entry[ret_tag].valid <= 1'b0;
            end else begin
               err <= 1'b1;
            end
         end
         if (set_en) begin
            entry[set_tag] <= '{valid: 1'b1, owner: set_owner};
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and DM ports onto one tagged memory and routes each
// returning load back to the port that issued it.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TAG_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       if2arb_command,
   input  logic [31:0]      if2arb_addr,
   output logic [TAG_W-1:0] arb2if_response,
   output logic [31:0]      arb2if_data,
   output logic [TAG_W-1:0] arb2if_tag,
   input  logic [1:0]       dm2arb_command,
   input  logic [31:0]      dm2arb_addr,
   input  logic [31:0]      dm2arb_data,
   output logic [TAG_W-1:0] arb2dm_response,
   output logic [31:0]      arb2dm_data,
   output logic [TAG_W-1:0] arb2dm_tag,
   output logic [1:0]       arb2mem_command,
   output logic [31:0]      arb2mem_addr,
   output logic [31:0]      arb2mem_data,
   input  logic [TAG_W-1:0] mem2arb_response,
   input  logic [31:0]      mem2arb_data,
   input  logic [TAG_W-1:0] mem2arb_tag,
   output logic             arb_grant_dm,
   output logic             arb_err
);

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);

   logic       req_if;
   logic       req_dm;
   logic       grant_if;
   logic       grant_dm;
   logic       if_accepted;
   logic [2:0] starve_cnt;
   logic       tbl_set;
   owner_t     tbl_set_owner;
   logic       ret_hit;
   owner_t     ret_owner;

   // Grant selection: DM by default, IF once it has been starved long enough.
   always_comb begin
      req_if      = rst && (if2arb_command != BUS_NONE);
      req_dm      = rst && (dm2arb_command != BUS_NONE);
      grant_dm    = req_dm && !(req_if && (starve_cnt >= STARVE_LIM));
      grant_if    = req_if && !grant_dm;
      if_accepted = grant_if && (mem2arb_response != '0);
   end

   // Forward the granted request and steer the accept tag back to it.
   always_comb begin
      arb2mem_command = BUS_NONE;
      arb2mem_addr    = '0;
      arb2mem_data    = '0;
      arb2if_response = '0;
      arb2dm_response = '0;
      tbl_set         = 1'b0;
      tbl_set_owner   = OWN_IF;
      if (grant_dm) begin
         arb2mem_command = dm2arb_command;
         arb2mem_addr    = dm2arb_addr;
         arb2mem_data    = dm2arb_data;
         arb2dm_response = mem2arb_response;
         tbl_set         = (dm2arb_command == BUS_LOAD) && (mem2arb_response != '0);
         tbl_set_owner   = OWN_DM;
      end else if (grant_if) begin
         arb2mem_command = if2arb_command;
         arb2mem_addr    = if2arb_addr;
         arb2if_response = mem2arb_response;
         tbl_set         = (if2arb_command == BUS_LOAD) && (mem2arb_response != '0);
         tbl_set_owner   = OWN_IF;
      end
   end

   // Route a returning load to whichever port owns its tag.
   always_comb begin
      arb2if_data  = '0;
      arb2if_tag   = '0;
      arb2dm_data  = '0;
      arb2dm_tag   = '0;
      arb_grant_dm = grant_dm;
      if (rst && ret_hit) begin
         if (ret_owner == OWN_DM) begin
            arb2dm_data = mem2arb_data;
            arb2dm_tag  = mem2arb_tag;
         end else begin
            arb2if_data = mem2arb_data;
            arb2if_tag  = mem2arb_tag;
         end
      end
   end

   // Count consecutive cycles an IF request goes unaccepted, saturating at 7.
   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!req_if || if_accepted) begin
         starve_cnt <= '0;
      end else if (starve_cnt != 3'd7) begin
         starve_cnt <= starve_cnt + 3'd1;
      end
   end

   arb_tag_table #(
      .TAG_W (TAG_W)
   ) u_tag_table (
      .clk       (clk),
      .rst       (rst),
      .set_en    (tbl_set),
      .set_tag   (mem2arb_response),
      .set_owner (tbl_set_owner),
      .ret_tag   (mem2arb_tag),
      .ret_hit   (ret_hit),
      .ret_owner (ret_owner),
      .err       (arb_err)
   );

endmodule
